// File: rtl/proc_params.sv
// rtl/proc_params.sv - shared RV32I decode constants, issue record and forwarding helper for the ALU issue stage
package proc_params;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    // func bit that turns ADD into SUB and SRL into SRA
    localparam int FUNC_SUB_SRA_BIT = 8;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_kind_e;
    typedef enum logic [1:0] {A_ZERO, A_RS1, A_PC} a_sel_e;
    typedef enum logic [2:0] {B_ZERO, B_RS2, B_IMM, B_FOUR, B_SHAMT} b_sel_e;

    typedef struct packed {
        logic [31:0] bits_a;
        logic [31:0] bits_b;
        logic [9:0]  func;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        wb_en;
        logic        is_branch;
        logic        is_load;
        logic        is_store;
        logic        illegal;
    } issue_t;

    // EX beats MEM beats the register file; x0 is hardwired and a pending load is never forwarded
    function automatic logic [31:0] fwd_src(
        input logic [4:0]  idx,
        input logic [31:0] rf_val,
        input logic        ex_en,
        input logic        ex_ld,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_data,
        input logic        mem_en,
        input logic [4:0]  mem_rd,
        input logic [31:0] mem_data
    );
        if (idx == 5'd0)                              return 32'd0;
        else if (ex_en && !ex_ld && ex_rd == idx)     return ex_data;
        else if (mem_en && mem_rd == idx)             return mem_data;
        else                                          return rf_val;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction and sign extension
module imm_gen
    import proc_params::*;
(
    input  logic [31:0] instr,
    input  imm_kind_e   kind,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (kind)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/issue register stage feeding the ALU with forwarding and load-use stall
module alu_issue_stage
    import proc_params::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              ex_fwd_en,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_fwd_is_load,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_bits_a,
    output logic [XLEN-1:0]   out_bits_b,
    output logic [9:0]        out_func,
    output logic [XLEN-1:0]   out_rs2_val,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wb_en,
    output logic              out_is_branch,
    output logic              out_is_load,
    output logic              out_is_store,
    output logic              out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic        legal, use_rs1, use_rs2, writes_rd, hazard;
    logic        dec_branch, dec_load, dec_store;
    imm_kind_e   kind;
    a_sel_e      sel_a;
    b_sel_e      sel_b;
    logic [9:0]  func;
    logic [31:0] imm, src1, src2;
    issue_t      nxt, issue_q;

    assign opcode  = in_instr[6:0];
    assign funct3  = in_instr[14:12];
    assign rd_idx  = in_instr[11:7];
    assign rs1_idx = in_instr[19:15];
    assign rs2_idx = in_instr[24:20];

    always_comb begin
        legal = 1'b1;  use_rs1 = 1'b0;  use_rs2 = 1'b0;  writes_rd = 1'b0;
        dec_branch = 1'b0;  dec_load = 1'b0;  dec_store = 1'b0;
        kind = IMM_NONE;  sel_a = A_ZERO;  sel_b = B_ZERO;  func = '0;
        unique case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;  use_rs2 = 1'b1;  writes_rd = 1'b1;
                sel_a = A_RS1;  sel_b = B_RS2;  func = {in_instr[31:25], funct3};
            end
            OPC_OP_IMM: begin
                use_rs1 = 1'b1;  writes_rd = 1'b1;  kind = IMM_I;  sel_a = A_RS1;
                func = {7'b0, funct3};
                // shift-immediates carry only the shamt as operand B; imm[10] selects SRAI
                if (funct3 == F3_SLL || funct3 == F3_SRL_SRA) sel_b = B_SHAMT;
                else                                           sel_b = B_IMM;
                if (funct3 == F3_SRL_SRA && in_instr[30]) func[FUNC_SUB_SRA_BIT] = 1'b1;
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;  writes_rd = 1'b1;  dec_load = 1'b1;
                kind = IMM_I;  sel_a = A_RS1;  sel_b = B_IMM;
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;  use_rs2 = 1'b1;  dec_store = 1'b1;
                kind = IMM_S;  sel_a = A_RS1;  sel_b = B_IMM;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;  use_rs2 = 1'b1;  dec_branch = 1'b1;
                kind = IMM_B;  sel_a = A_RS1;  sel_b = B_RS2;  func = {7'b0, funct3};
            end
            OPC_LUI:   begin writes_rd = 1'b1;  kind = IMM_U;  sel_a = A_ZERO;  sel_b = B_IMM; end
            OPC_AUIPC: begin writes_rd = 1'b1;  kind = IMM_U;  sel_a = A_PC;    sel_b = B_IMM; end
            OPC_JAL:   begin writes_rd = 1'b1;  kind = IMM_J;  sel_a = A_PC;    sel_b = B_FOUR; end
            OPC_JALR: begin
                use_rs1 = 1'b1;  writes_rd = 1'b1;  kind = IMM_I;  sel_a = A_PC;  sel_b = B_FOUR;
            end
            default: legal = 1'b0;
        endcase
    end

    imm_gen u_imm_gen (
        .instr (in_instr),
        .kind  (kind),
        .imm   (imm)
    );

    assign src1 = fwd_src(rs1_idx, rs1_data, ex_fwd_en, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
                          mem_fwd_en, mem_fwd_rd, mem_fwd_data);
    assign src2 = fwd_src(rs2_idx, rs2_data, ex_fwd_en, ex_fwd_is_load, ex_fwd_rd, ex_fwd_data,
                          mem_fwd_en, mem_fwd_rd, mem_fwd_data);

    assign hazard = ex_fwd_en && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                    ((use_rs1 && ex_fwd_rd == rs1_idx) || (use_rs2 && ex_fwd_rd == rs2_idx));

    assign in_ready = !hazard && (!out_valid || out_ready);

    always_comb begin
        nxt    = '0;
        nxt.pc = in_pc;
        if (legal) begin
            unique case (sel_a)
                A_RS1:   nxt.bits_a = src1;
                A_PC:    nxt.bits_a = in_pc;
                default: nxt.bits_a = '0;
            endcase
            unique case (sel_b)
                B_RS2:   nxt.bits_b = src2;
                B_IMM:   nxt.bits_b = imm;
                B_FOUR:  nxt.bits_b = 32'd4;
                B_SHAMT: nxt.bits_b = {27'b0, rs2_idx};
                default: nxt.bits_b = '0;
            endcase
            nxt.func      = func;
            nxt.rs2_val   = src2;
            nxt.imm       = imm;
            nxt.rd        = writes_rd ? rd_idx : 5'd0;
            nxt.wb_en     = writes_rd && (rd_idx != 5'd0);
            nxt.is_branch = dec_branch;
            nxt.is_load   = dec_load;
            nxt.is_store  = dec_store;
        end else begin
            nxt.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            issue_q   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            issue_q   <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_bits_a    = issue_q.bits_a;
    assign out_bits_b    = issue_q.bits_b;
    assign out_func      = issue_q.func;
    assign out_rs2_val   = issue_q.rs2_val;
    assign out_imm       = issue_q.imm;
    assign out_pc        = issue_q.pc;
    assign out_rd        = issue_q.rd;
    assign out_wb_en     = issue_q.wb_en;
    assign out_is_branch = issue_q.is_branch;
    assign out_is_load   = issue_q.is_load;
    assign out_is_store  = issue_q.is_store;
    assign out_illegal   = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a, b;
        logic [9:0]  func;
        logic [31:0] rs2_val, imm, pc;
        logic [4:0]  rd;
        logic        wb_en, is_branch, is_load, is_store, illegal;
    } exp_t;

    typedef struct packed {
        logic        rst, in_valid;
        logic [31:0] instr, pc, rs1_data, rs2_data;
        logic        ex_en;
        logic [4:0]  ex_rd;
        logic [31:0] ex_data;
        logic        ex_ld, mem_en;
        logic [4:0]  mem_rd;
        logic [31:0] mem_data;
        logic        flush, out_ready;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, ex_fwd_en, ex_fwd_is_load, mem_fwd_en, flush;
    logic        out_valid, out_ready, out_wb_en, out_is_branch, out_is_load, out_is_store, out_illegal;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data, ex_fwd_data, mem_fwd_data;
    logic [31:0] out_bits_a, out_bits_b, out_rs2_val, out_imm, out_pc;
    logic [4:0]  ex_fwd_rd, mem_fwd_rd, out_rd;
    logic [9:0]  out_func;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   started = 1'b0;
    bit   held    = 1'b0;
    exp_t q[$];

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_fwd_en(ex_fwd_en),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data), .ex_fwd_is_load(ex_fwd_is_load),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_bits_a(out_bits_a),
        .out_bits_b(out_bits_b), .out_func(out_func), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
        .out_pc(out_pc), .out_rd(out_rd), .out_wb_en(out_wb_en), .out_is_branch(out_is_branch),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_illegal(out_illegal)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic exp_t actual();
        return '{out_bits_a, out_bits_b, out_func, out_rs2_val, out_imm, out_pc, out_rd,
                 out_wb_en, out_is_branch, out_is_load, out_is_store, out_illegal};
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf, input stim_t s);
        if (idx == 0)                                return 0;
        if (s.ex_en && !s.ex_ld && s.ex_rd == idx)   return s.ex_data;
        if (s.mem_en && s.mem_rd == idx)             return s.mem_data;
        return rf;
    endfunction

    function automatic bit hazard(input stim_t s);
        logic [6:0] opc;
        bit u1, u2;
        opc = s.instr[6:0];
        u1 = opc inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        u2 = opc inside {7'h33, 7'h23, 7'h63};
        return s.ex_en && s.ex_ld && s.ex_rd != 0 &&
               ((u1 && s.ex_rd == s.instr[19:15]) || (u2 && s.ex_rd == s.instr[24:20]));
    endfunction

    // reference decode: immediates built arithmetically from the RV32I field layout
    function automatic exp_t model(input stim_t s);
        exp_t e;
        logic [31:0] ins, sx, i_imm, s_imm, b_imm, u_imm, j_imm, v1, v2;
        logic [2:0] f3;
        bit wr;
        ins   = s.instr;
        f3    = ins[14:12];
        sx    = {32{ins[31]}};
        i_imm = 32'($signed(ins) >>> 20);
        s_imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
        b_imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        u_imm = ins & 32'hFFFF_F000;
        j_imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        v1    = operand(ins[19:15], s.rs1_data, s);
        v2    = operand(ins[24:20], s.rs2_data, s);
        e     = '0;
        e.pc  = s.pc;
        e.rs2_val = v2;
        wr    = 1'b1;
        case (ins[6:0])
            7'h33: begin e.a = v1; e.b = v2; e.func = {ins[31:25], f3}; end
            7'h13: begin
                e.a = v1; e.imm = i_imm;
                e.b = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : i_imm;
                e.func = 10'(f3) + ((f3 == 3'd5 && ins[30]) ? 10'h100 : 10'h0);
            end
            7'h03: begin e.a = v1; e.b = i_imm; e.imm = i_imm; e.is_load = 1; end
            7'h23: begin e.a = v1; e.b = s_imm; e.imm = s_imm; e.is_store = 1; wr = 0; end
            7'h63: begin e.a = v1; e.b = v2; e.imm = b_imm; e.func = 10'(f3); e.is_branch = 1; wr = 0; end
            7'h37: begin e.b = u_imm; e.imm = u_imm; end
            7'h17: begin e.a = s.pc; e.b = u_imm; e.imm = u_imm; end
            7'h6F: begin e.a = s.pc; e.b = 4; e.imm = j_imm; end
            7'h67: begin e.a = s.pc; e.b = 4; e.imm = i_imm; end
            default: begin e.illegal = 1; e.rs2_val = 0; wr = 0; end
        endcase
        e.rd    = wr ? ins[11:7] : 5'd0;
        e.wb_en = wr && ins[11:7] != 0;
        return e;
    endfunction

    always begin
        @(negedge clk);
        #2;
        if (started) begin
            check("out_valid", 256'(out_valid), 256'(q.size() != 0));
            if (q.size() != 0) begin
                if (out_valid) check("issue_fields", 256'(actual()), 256'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic do_cycle(input stim_t s);
        bit exp_rdy;
        @(negedge clk);
        rst = s.rst; in_valid = s.in_valid; in_instr = s.instr; in_pc = s.pc;
        rs1_data = s.rs1_data; rs2_data = s.rs2_data;
        ex_fwd_en = s.ex_en; ex_fwd_rd = s.ex_rd; ex_fwd_data = s.ex_data; ex_fwd_is_load = s.ex_ld;
        mem_fwd_en = s.mem_en; mem_fwd_rd = s.mem_rd; mem_fwd_data = s.mem_data;
        flush = s.flush; out_ready = s.out_ready;
        #3;
        exp_rdy = !hazard(s) && (!held || s.out_ready);
        if (!s.rst) check("in_ready", 256'(in_ready), 256'(exp_rdy));
        if (s.rst) begin
            held = 0;
            q.delete();
        end else if (s.flush) begin
            if (held && !s.out_ready) void'(q.pop_back());
            held = 0;
        end else if (s.in_valid && exp_rdy) begin
            q.push_back(model(s));
            held = 1;
        end else if (s.out_ready) begin
            held = 0;
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.out_ready = 1;
        return s;
    endfunction

    function automatic stim_t insn(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
        stim_t s;
        s = idle();
        s.in_valid = 1; s.instr = instr; s.pc = 32'h1000; s.rs1_data = r1; s.rs2_data = r2;
        return s;
    endfunction

    logic [6:0] opc_tab [12];

    initial begin
        stim_t s;
        opc_tab = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h13, 7'h7F, 7'h0B};
        s = idle();
        s.rst = 1;
        rst = 1; in_valid = 0; in_instr = 0; in_pc = 0; rs1_data = 0; rs2_data = 0;
        ex_fwd_en = 0; ex_fwd_rd = 0; ex_fwd_data = 0; ex_fwd_is_load = 0;
        mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_data = 0; flush = 0; out_ready = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #2;
        check("reset_valid", 256'(out_valid), 256'(0));
        check("reset_fields", 256'(actual()), 256'(0));
        check("reset_in_ready", 256'(in_ready), 256'(1));
        started = 1;

        // add x3,x1,x2
        do_cycle(insn(32'h0020_81B3, 5, 7));
        // sub x4,x1,x2 with EX and MEM both forwarding x1
        s = insn(32'h4020_8233, 1, 2);
        s.ex_en = 1; s.ex_rd = 1; s.ex_data = 32'h10; s.mem_en = 1; s.mem_rd = 1; s.mem_data = 32'h20;
        do_cycle(s);
        // load-use on x2, then the load data arrives via MEM
        s = insn(32'h0020_81B3, 5, 7);
        s.ex_en = 1; s.ex_ld = 1; s.ex_rd = 2; s.ex_data = 32'hDEAD;
        do_cycle(s);
        s.ex_en = 0; s.mem_en = 1; s.mem_rd = 2; s.mem_data = 32'h99;
        do_cycle(s);
        // hold for three cycles with a waiting instruction
        s = insn(32'h0031_0233, 9, 11);
        s.out_ready = 0;
        repeat (3) do_cycle(s);
        s.out_ready = 1;
        do_cycle(s);
        // flush with a held instruction and a new one waiting
        s = insn(32'h0020_81B3, 1, 2);
        s.out_ready = 0;
        do_cycle(s);
        s.flush = 1;
        do_cycle(s);
        // srai, lui, illegal opcode
        do_cycle(insn(32'h4033_5293, 32'h8000_0000, 0));
        do_cycle(insn(32'h1234_53B7, 1, 2));
        do_cycle(insn(32'h0000_007F, 1, 2));
        do_cycle(idle());

        for (int i = 0; i < 2000; i++) begin
            s.rst       = (i == 1000);
            s.in_valid  = $urandom_range(0, 3) != 0;
            s.instr     = $urandom;
            s.instr[6:0]   = opc_tab[$urandom_range(0, 11)];
            s.instr[11:7]  = 5'($urandom_range(0, 3));
            s.instr[19:15] = 5'($urandom_range(0, 3));
            s.instr[24:20] = 5'($urandom_range(0, 3));
            s.pc        = $urandom & 32'hFFFF_FFFC;
            s.rs1_data  = $urandom;
            s.rs2_data  = $urandom;
            s.ex_en     = $urandom_range(0, 1) != 0;
            s.ex_rd     = 5'($urandom_range(0, 3));
            s.ex_data   = $urandom;
            s.ex_ld     = $urandom_range(0, 3) == 0;
            s.mem_en    = $urandom_range(0, 1) != 0;
            s.mem_rd    = 5'($urandom_range(0, 3));
            s.mem_data  = $urandom;
            s.flush     = $urandom_range(0, 15) == 0;
            s.out_ready = $urandom_range(0, 2) != 0;
            do_cycle(s);
        end
        repeat (3) do_cycle(idle());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
